im_loader: RTL

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Instruction-memory loader: receives a length-prefixed byte frame, writes packed
// 32-bit words into IM, verifies an XOR checksum and releases the CPU from reset.
module im_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // LEN_HI | expecting high byte of word count
  // LEN_LO | expecting low byte of word count
  // DATA   | assembling payload words
  // CHECK  | expecting checksum byte
  // DONE   | image loaded, CPU released
  // ERR    | length overflow or bad checksum, CPU held
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_W);

  state_t state, state_nxt;

  logic [7:0]      len_hi;
  logic [15:0]     len;
  logic [15:0]     len_in;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift;
  logic [7:0]      csum;
  logic [ADDR_W:0] wc_nxt;
  logic            xfer;
  logic            start_ok;
  logic            len_too_big;
  logic            last_word;
  logic            word_done;

  assign len_in      = {len_hi, in_data};
  assign len_too_big = {1'b0, len_in} > MAX_N;
  assign wc_nxt      = word_count + 1'b1;
  assign last_word   = 32'(wc_nxt) == 32'(len);

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start_ok  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        start_ok = start;
        if (start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (len_too_big)       state_nxt = S_ERR;
          else if (len_in == '0) state_nxt = S_CHECK;
          else                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == 2'd3 && last_word) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
    xfer      = in_ready & in_valid;
    word_done = (state == S_DATA) && xfer && (byte_cnt == 2'd3);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      len_hi     <= '0;
      len        <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      csum       <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      im_we <= 1'b0;
      if (start_ok) begin
        done       <= 1'b0;
        err        <= 1'b0;
        word_count <= '0;
        csum       <= '0;
        byte_cnt   <= '0;
        cpu_hold   <= 1'b1;
      end
      if (xfer) begin
        case (state)
          S_LEN_HI: len_hi <= in_data;
          S_LEN_LO: begin
            len <= len_in;
            if (len_too_big) err <= 1'b1;
          end
          S_DATA: begin
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], in_data};
          end
          S_CHECK: begin
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // word index equals words written so far, so the last of 2^ADDR_W lands at the top address
      if (word_done) begin
        im_we      <= 1'b1;
        im_addr    <= word_count[ADDR_W-1:0];
        im_wdata   <= {shift, in_data};
        word_count <= wc_nxt;
      end
    end
  end

endmodule
